// File: rtl/credit_link_pkg.sv
// Shared state encoding, stats width and credit-counter width helper for the
// credit-flow link transmitter.
package credit_link_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } tx_state_e;

  localparam int STATS_W = 32;

  function automatic int credit_cnt_width(input int credits);
    return $clog2(credits + 1);
  endfunction

endpackage

// File: rtl/simple_credit_counter.sv
// Saturating up/down credit counter with a synchronous load and a sticky
// overflow flag that is set when an increment would pass MAX_COUNT.
module simple_credit_counter #(
  parameter int MAX_COUNT = 32,
  parameter int CW        = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic [CW-1:0] count_o,
  output logic          overflow_o
);

  localparam logic [CW-1:0] MAX_VAL = CW'(MAX_COUNT);
  localparam logic [CW-1:0] ONE     = CW'(1);

  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  // A matching inc and dec cancel; the flag survives loads and clears only on reset.
  always_comb begin
    count_d    = count_q;
    overflow_d = overflow_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (inc_i && !dec_i) begin
      if (count_q == MAX_VAL) overflow_d = 1'b1;
      else                    count_d    = count_q + ONE;
    end else if (dec_i && !inc_i && (count_q != '0)) begin
      count_d = count_q - ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/simple_credit_tx.sv
// Credit-flow link transmitter: spends one credit per beat sent to a remote FIFO,
// with link bring-up and flush/drain. Optional counters under CREDIT_TX_STATS_EN.
module simple_credit_tx
  import credit_link_pkg::*;
#(
  parameter  int DATA_WIDTH = 64,
  parameter  int CREDITS    = 32,
  localparam int CW         = credit_cnt_width(CREDITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  link_up,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  credit_ret,
  input  logic                  flush,
  output logic                  flush_done,
  output logic [CW-1:0]         credit_cnt,
  output logic                  err_overflow
`ifdef CREDIT_TX_STATS_EN
  ,
  output logic [STATS_W-1:0]    stat_sent,
  output logic [STATS_W-1:0]    stat_stall
`endif
);

  localparam logic [CW-1:0] FULL_CNT = CW'(CREDITS);

  tx_state_e             state_q;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic                  m_valid_q;
  logic                  flush_done_q;

  logic                  accept;
  logic                  cnt_load;
  logic [CW-1:0]         cnt_load_val;
  logic                  cnt_full;

  // Ready depends only on registered state so it never loops back through s_valid.
  assign s_ready  = (state_q == ST_RUN) && (credit_cnt != '0);
  assign accept   = s_valid && s_ready && link_up;
  assign cnt_full = (credit_cnt == FULL_CNT);

  // Link loss zeroes the counter; bring-up out of INIT refills it.
  assign cnt_load     = !link_up || (state_q == ST_INIT);
  assign cnt_load_val = link_up ? FULL_CNT : '0;

  simple_credit_counter #(
    .MAX_COUNT (CREDITS),
    .CW        (CW)
  ) u_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .inc_i      (credit_ret),
    .dec_i      (accept),
    .count_o    (credit_cnt),
    .overflow_o (err_overflow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_INIT;
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      m_valid_q    <= accept;
      flush_done_q <= 1'b0;
      if (accept) m_data_q <= s_data;
      if (!link_up) begin
        state_q <= ST_INIT;
      end else begin
        case (state_q)
          ST_INIT:  state_q <= ST_RUN;
          ST_RUN:   if (flush) state_q <= ST_DRAIN;
          ST_DRAIN: begin
            if (cnt_full) begin
              flush_done_q <= 1'b1;
              state_q      <= ST_RUN;
            end
          end
          default:  state_q <= ST_INIT;
        endcase
      end
    end
  end

  assign m_data     = m_data_q;
  assign m_valid    = m_valid_q;
  assign flush_done = flush_done_q;

`ifdef CREDIT_TX_STATS_EN
  logic [STATS_W-1:0] stat_sent_q;
  logic [STATS_W-1:0] stat_stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_sent_q  <= '0;
      stat_stall_q <= '0;
    end else begin
      if (accept) stat_sent_q <= stat_sent_q + STATS_W'(1);
      if ((state_q == ST_RUN) && s_valid && !s_ready) stat_stall_q <= stat_stall_q + STATS_W'(1);
    end
  end

  assign stat_sent  = stat_sent_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_simple_credit_tx.sv
// Randomized and directed bench for simple_credit_tx, checked against a
// transaction-level model that tracks outstanding beats rather than credits.
module tb_simple_credit_tx;

  localparam int DW = 64;
  localparam int CR = 32;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          link_up;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          credit_ret;
  logic          flush;
  logic          flush_done;
  logic [CW-1:0] credit_cnt;
  logic          err_overflow;
`ifdef CREDIT_TX_STATS_EN
  logic [31:0]   stat_sent;
  logic [31:0]   stat_stall;
`endif

  simple_credit_tx #(
    .DATA_WIDTH (DW),
    .CREDITS    (CR)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .link_up      (link_up),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .credit_ret   (credit_ret),
    .flush        (flush),
    .flush_done   (flush_done),
    .credit_cnt   (credit_cnt),
    .err_overflow (err_overflow)
`ifdef CREDIT_TX_STATS_EN
    ,
    .stat_sent    (stat_sent),
    .stat_stall   (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  int testsRun    = 0;
  int testsFailed = 0;
  int beats       = 0;
  int flushPulses = 0;

  // Model: "linked" means the far side is up; credits = CREDITS - beats in flight.
  bit            mLinked, mDraining, mValid, mFlushDone, mErr;
  int            mOut;
  logic [DW-1:0] mData;
  int            mSent, mStall;

  function automatic bit expReady();
    return mLinked && !mDraining && (mOut < CR);
  endfunction

  function automatic int expCredits();
    return mLinked ? (CR - mOut) : 0;
  endfunction

  task automatic modelReset();
    mLinked = 0; mDraining = 0; mValid = 0; mFlushDone = 0; mErr = 0;
    mOut = 0; mData = '0; mSent = 0; mStall = 0;
  endtask

  task automatic modelStep(input bit lu, input bit sv, input logic [DW-1:0] sd,
                           input bit cr, input bit fl);
    bit send;
    send = expReady() && sv && lu;
    if (mLinked && !mDraining && sv && !expReady()) mStall++;
    if (send) mSent++;
    mValid     = send;
    mFlushDone = 0;
    if (send) mData = sd;
    if (!lu) begin
      mLinked = 0; mDraining = 0; mOut = 0;
    end else if (!mLinked) begin
      mLinked = 1; mOut = 0;
    end else begin
      if (mDraining && mOut == 0) begin
        mFlushDone = 1;
        mDraining  = 0;
      end else if (!mDraining && fl) begin
        mDraining = 1;
      end
      if (cr && !send) begin
        if (mOut == 0) mErr = 1;
        else           mOut--;
      end else if (send && !cr) begin
        mOut++;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkAll();
    checkOutput("credit_cnt", DW'(credit_cnt), DW'(expCredits()));
    checkOutput("s_ready", DW'(s_ready), DW'(expReady()));
    checkOutput("m_valid", DW'(m_valid), DW'(mValid));
    checkOutput("m_data", m_data, mData);
    checkOutput("flush_done", DW'(flush_done), DW'(mFlushDone));
    checkOutput("err_overflow", DW'(err_overflow), DW'(mErr));
`ifdef CREDIT_TX_STATS_EN
    checkOutput("stat_sent", DW'(stat_sent), DW'(mSent));
    checkOutput("stat_stall", DW'(stat_stall), DW'(mStall));
`endif
    if (m_valid === 1'b1) beats++;
    if (flush_done === 1'b1) flushPulses++;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked there too.
  task automatic applyStimulus(input bit lu, input bit sv, input logic [DW-1:0] sd,
                               input bit cr, input bit fl);
    link_up = lu; s_valid = sv; s_data = sd; credit_ret = cr; flush = fl;
    modelStep(lu, sv, sd, cr, fl);
    @(posedge clk);
    #1;
    checkAll();
  endtask

  initial begin
    logic [DW-1:0] d;
    rst_n = 1'b0; link_up = 0; s_valid = 0; s_data = '0; credit_ret = 0; flush = 0;
    modelReset();
    #12;
    checkAll();
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Bring-up
    applyStimulus(0, 0, '0, 0, 0);
    applyStimulus(0, 0, '0, 0, 0);
    applyStimulus(1, 0, '0, 0, 0);
    checkOutput("bringup_cnt", DW'(credit_cnt), DW'(CR));
    checkOutput("bringup_ready", DW'(s_ready), DW'(1));

    // Full burst with no returns exhausts credits
    beats = 0;
    for (int i = 0; i < CR + 3; i++) applyStimulus(1, 1, DW'(64'h1000 + i), 0, 0);
    checkOutput("burst_beats", DW'(beats), DW'(CR));
    checkOutput("burst_ready", DW'(s_ready), DW'(0));
    checkOutput("burst_cnt", DW'(credit_cnt), DW'(0));

    // Single return re-opens the gate; send+return holds the count
    applyStimulus(1, 0, '0, 1, 0);
    applyStimulus(1, 1, 64'hABCD, 0, 0);
    checkOutput("reuse_cnt", DW'(credit_cnt), DW'(0));
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, '0, 1, 0);
    applyStimulus(1, 1, 64'h5555, 1, 0);
    checkOutput("sendret_cnt", DW'(credit_cnt), DW'(5));

    // Drain with 16 outstanding
    for (int i = 0; i < 11; i++) applyStimulus(1, 0, '0, 1, 0);
    applyStimulus(1, 0, '0, 0, 1);
    checkOutput("drain_ready", DW'(s_ready), DW'(0));
    flushPulses = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, 1, '0, 1, 0);
      applyStimulus(1, 1, '0, 0, (i == 8));
    end
    applyStimulus(1, 0, '0, 0, 0);
    checkOutput("flush_pulses", DW'(flushPulses), DW'(1));
    checkOutput("post_flush_ready", DW'(s_ready), DW'(1));

    // Overflow is sticky
    applyStimulus(1, 0, '0, 1, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, '0, 0, 0);
    checkOutput("err_sticky", DW'(err_overflow), DW'(1));

    // Link drop mid-burst
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, DW'(64'h2000 + i), 0, 0);
    applyStimulus(0, 1, 64'hDEAD, 0, 0);
    checkOutput("drop_valid", DW'(m_valid), DW'(0));
    checkOutput("drop_cnt", DW'(credit_cnt), DW'(0));
    applyStimulus(1, 0, '0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, DW'(64'h3000 + i), 0, 0);

    // Asynchronous reset in the middle of a send
    s_valid = 1; s_data = 64'hBEEF;
    #3;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkAll();
    checkOutput("async_rst_valid", DW'(m_valid), DW'(0));
    #2;
    rst_n = 1'b1;
    applyStimulus(1, 0, '0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      bit lu, sv, cr, fl;
      lu = ($urandom_range(0, 99) != 0);
      sv = ($urandom_range(0, 3) != 0);
      d  = {$urandom, $urandom};
      cr = (mOut > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 49) == 0);
      fl = ($urandom_range(0, 29) == 0);
      applyStimulus(lu, sv, d, cr, fl);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
